// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - LC-3 control FSM state encoding, opcodes and datapath select encodings
//
// Purpose: shared types and constants for the LC-3 sequencer.
// Contents: state_t (5-bit state encoding), opcode constants, PCMUX/ADDR2MUX/ALUK
//           encodings, is_mem_state() helper.
package lc3_ctrl_pkg;

  // Numeric states keep their textbook numbers where they fit in 5 bits;
  // S32/S33/S35 and the pause/halt states take otherwise unused codes.
  typedef enum logic [4:0] {
    S00    = 5'd0,
    S01    = 5'd1,
    S32    = 5'd2,
    S33    = 5'd3,
    S04    = 5'd4,
    S05    = 5'd5,
    S06    = 5'd6,
    S07    = 5'd7,
    S35    = 5'd8,
    S09    = 5'd9,
    PAUSE1 = 5'd10,
    PAUSE2 = 5'd11,
    S12    = 5'd12,
    S16    = 5'd16,
    S18    = 5'd18,
    S21    = 5'd21,
    S22    = 5'd22,
    S23    = 5'd23,
    S25    = 5'd25,
    S27    = 5'd27,
    HALTED = 5'd31
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO   = 2'b00;
  localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
  localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
  localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  // States that hold for MEM_WAIT cycles while the SRAM is strobed.
  function automatic logic is_mem_state(state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// rtl/lc3_control_fsm_if.sv - LC-3 controller <-> datapath control bundle
//
// Purpose: groups the datapath status inputs (IR, BEN) and every datapath
//          control output of the sequencer.
// Modports: master = controller (drives controls, reads IR/BEN),
//           slave  = datapath (reads controls, drives IR/BEN).
interface lc3_control_fsm_if;
  logic [15:0] IR;
  logic        BEN;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN;
  logic        Mem_OE, Mem_WE;

  modport master (
    input  IR, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR2MUX, ALUK,
    output ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN,
    output Mem_OE, Mem_WE
  );

  modport slave (
    output IR, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR2MUX, ALUK,
    input  ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN,
    input  Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_control_fsm_mem_wait_timer.sv
// rtl/lc3_control_fsm_mem_wait_timer.sv - SRAM access wait counter for the LC-3 sequencer
//
// Purpose: counts cycles spent in a memory state; done_o is high in the last
//          (MEM_WAIT-th) cycle so the FSM leaves on the following edge.
// Ports: Clk, Reset (async active-low), load_i (clear, asserted on entry to a
//        memory state), run_i (currently in a memory state), done_o.
module mem_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load_i,
  input  logic run_i,
  output logic done_o
);
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = run_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = '0;
    else if (run_i && !done_o)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - LC-3 fetch/decode/execute control sequencer
//
// Purpose: Moore FSM driving every datapath control for ADD, AND, NOT, BR,
//          JMP, JSR, LDR, STR and PAUSE; times SRAM accesses via mem_wait_timer.
// Ports: Clk, Reset (async active-low), Run (start, HALTED only), Continue
//        (pause release), ctrl (IR/BEN in, all control outputs),
//        State_Dbg (current state encoding).
module lc3_control_fsm
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run,
  input  logic                Continue,
  lc3_control_fsm_if.master   ctrl,
  output logic [4:0]          State_Dbg
);
  state_t state_q, state_d;
  logic   mem_done;

  mem_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .load_i (is_mem_state(state_d) && !is_mem_state(state_q)),
    .run_i  (is_mem_state(state_q)),
    .done_o (mem_done)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= HALTED;
    else        state_q <= state_d;
  end

  assign State_Dbg   = state_q;
  assign ctrl.SR2MUX = ctrl.IR[5];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HALTED: if (Run) state_d = S18;
      S18:    state_d = S33;
      S33:    if (mem_done) state_d = S35;
      S35:    state_d = S32;
      S32: begin
        case (ctrl.IR[15:12])
          OP_ADD:   state_d = S01;
          OP_AND:   state_d = S05;
          OP_NOT:   state_d = S09;
          OP_BR:    state_d = S00;
          OP_JMP:   state_d = S12;
          OP_JSR:   state_d = S04;
          OP_LDR:   state_d = S06;
          OP_STR:   state_d = S07;
          OP_PAUSE: state_d = PAUSE1;
          default:  state_d = S18;
        endcase
      end
      S01, S05, S09, S12, S21, S22, S27: state_d = S18;
      S00:    state_d = ctrl.BEN ? S22 : S18;
      S04:    state_d = S21;
      S06:    state_d = S25;
      S25:    if (mem_done) state_d = S27;
      S07:    state_d = S23;
      S23:    state_d = S16;
      S16:    if (mem_done) state_d = S18;
      PAUSE1: if (Continue)  state_d = PAUSE2;
      PAUSE2: if (!Continue) state_d = S18;
      default: state_d = HALTED;
    endcase
  end

  always_comb begin
    ctrl.LD_MAR = 1'b0; ctrl.LD_MDR = 1'b0; ctrl.LD_IR  = 1'b0; ctrl.LD_BEN = 1'b0;
    ctrl.LD_CC  = 1'b0; ctrl.LD_REG = 1'b0; ctrl.LD_PC  = 1'b0;
    ctrl.GatePC = 1'b0; ctrl.GateMDR = 1'b0; ctrl.GateALU = 1'b0; ctrl.GateMARMUX = 1'b0;
    ctrl.PCMUX  = PCMUX_PC1; ctrl.ADDR2MUX = ADDR2_ZERO; ctrl.ALUK = ALUK_ADD;
    ctrl.ADDR1MUX = 1'b0; ctrl.DRMUX = 1'b0; ctrl.SR1MUX = 1'b0; ctrl.MIO_EN = 1'b0;
    ctrl.Mem_OE = 1'b1; ctrl.Mem_WE = 1'b1;
    unique case (state_q)
      S18: begin ctrl.GatePC = 1'b1; ctrl.LD_MAR = 1'b1; ctrl.LD_PC = 1'b1; end
      S33, S25: begin ctrl.Mem_OE = 1'b0; ctrl.MIO_EN = 1'b1; ctrl.LD_MDR = 1'b1; end
      S35: begin ctrl.GateMDR = 1'b1; ctrl.LD_IR = 1'b1; end
      S32: ctrl.LD_BEN = 1'b1;
      S01, S05, S09: begin
        ctrl.SR1MUX = 1'b1; ctrl.GateALU = 1'b1; ctrl.LD_REG = 1'b1; ctrl.LD_CC = 1'b1;
        ctrl.ALUK = (state_q == S01) ? ALUK_ADD : (state_q == S05) ? ALUK_AND : ALUK_NOT;
      end
      S22: begin ctrl.ADDR2MUX = ADDR2_SEXT9; ctrl.PCMUX = PCMUX_ADDER; ctrl.LD_PC = 1'b1; end
      S12: begin
        ctrl.SR1MUX = 1'b1; ctrl.ADDR1MUX = 1'b1; ctrl.PCMUX = PCMUX_ADDER; ctrl.LD_PC = 1'b1;
      end
      S04: begin ctrl.GatePC = 1'b1; ctrl.DRMUX = 1'b1; ctrl.LD_REG = 1'b1; end
      S21: begin ctrl.ADDR2MUX = ADDR2_SEXT11; ctrl.PCMUX = PCMUX_ADDER; ctrl.LD_PC = 1'b1; end
      S06, S07: begin
        ctrl.ADDR1MUX = 1'b1; ctrl.ADDR2MUX = ADDR2_SEXT6; ctrl.SR1MUX = 1'b1;
        ctrl.GateMARMUX = 1'b1; ctrl.LD_MAR = 1'b1;
      end
      S27: begin ctrl.GateMDR = 1'b1; ctrl.LD_REG = 1'b1; ctrl.LD_CC = 1'b1; end
      // STR source register is IR[11:9], so SR1MUX stays 0 and PASS-A forwards it.
      S23: begin ctrl.ALUK = ALUK_PASSA; ctrl.GateALU = 1'b1; ctrl.LD_MDR = 1'b1; end
      S16: ctrl.Mem_WE = 1'b0;
      default: ;
    endcase
  end
endmodule
